aes_enc_ctrl: RTL and testbench

- Top-level sequencer for the AES-128 encryption core.
- Starts the key-schedule FSM and waits for its expanded-key bus to become valid.
- Accepts plaintext blocks over a valid/ready handshake and steps the round datapath through 11 round-key steps: initial AddRoundKey, NR-1 full rounds, one final round. It drives the round-key index used to slice the 1408-bit schedule.
- Returns ciphertext over a valid/ready handshake. Contains no datapath; control only.

---
 rtl/aes_enc_ctrl.sv | 153 +++++++++++++++
 tb/tb_aes_enc_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_ctrl.sv
// AES-128 encryption sequencer: key-expansion handshake, block accept,
// 11-step round sequencing and ciphertext return. Control only, no datapath.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key_load            request expansion of a new key
//   kexp_start          one-cycle pulse restarting the key schedule
//   key_ready           expanded-key bus valid
//   in_valid/in_ready   plaintext handshake
//   state_load          capture plaintext (same cycle as accept)
//   round_req/round_ack round step handshake with the datapath
//   round_op            0 AddRoundKey, 1 full round, 2 final round
//   round_idx           round-key index 0..NR
//   out_valid/out_ready ciphertext handshake
//   busy                not IDLE and not READY
//   key_err             sticky key-expansion timeout flag
module aes_enc_ctrl #(
  parameter int NR          = 10,
  parameter int KEY_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  output logic       kexp_start,
  input  logic       key_ready,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       state_load,
  output logic       round_req,
  input  logic       round_ack,
  output logic [1:0] round_op,
  output logic [3:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       key_err
);

  localparam int CW = $clog2(KEY_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEXP  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam logic [3:0]    IDX_LAST = 4'(NR);
  localparam logic [CW-1:0] CNT_LAST = CW'(KEY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SKIP = CW'(2);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          key_valid;
  logic          pend_key;
  logic          key_req;

  assign key_req    = key_load | pend_key;
  assign in_ready   = (state == S_READY) & key_valid & ~key_req;
  assign state_load = in_ready & in_valid;
  assign round_req  = (state == S_RUN);
  assign out_valid  = (state == S_OUT);
  assign busy       = (state != S_IDLE) & (state != S_READY);

  always_comb begin
    round_op = 2'd1;
    if (round_idx == 4'd0)
      round_op = 2'd0;
    else if (round_idx == IDX_LAST)
      round_op = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      key_valid  <= 1'b0;
      key_err    <= 1'b0;
      pend_key   <= 1'b0;
      kexp_start <= 1'b0;
      round_idx  <= 4'd0;
    end else begin
      kexp_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_load) begin
            kexp_start <= 1'b1;
            key_err    <= 1'b0;
            cnt        <= '0;
            state      <= S_KEXP;
          end
        end
        S_KEXP: begin
          // key_ready may still be high from the previous key for
          // the first two cycles, so it is only trusted from cnt 2
          if (key_load) begin
            kexp_start <= 1'b1;
            cnt        <= '0;
          end else if (key_ready && cnt >= CNT_SKIP) begin
            key_valid <= 1'b1;
            state     <= S_READY;
          end else if (cnt == CNT_LAST) begin
            key_err   <= 1'b1;
            key_valid <= 1'b0;
            cnt       <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READY: begin
          if (key_req) begin
            kexp_start <= 1'b1;
            key_err    <= 1'b0;
            pend_key   <= 1'b0;
            key_valid  <= 1'b0;
            cnt        <= '0;
            state      <= S_KEXP;
          end else if (state_load) begin
            round_idx <= 4'd0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (key_load)
            pend_key <= 1'b1;
          if (round_ack) begin
            if (round_idx == IDX_LAST) begin
              state <= S_OUT;
            end else begin
              round_idx <= round_idx + 4'd1;
              state     <= S_STEP;
            end
          end
        end
        S_STEP: begin
          // one idle cycle forces a fresh req rising edge per step
          if (key_load)
            pend_key <= 1'b1;
          state <= S_RUN;
        end
        S_OUT: begin
          if (key_load)
            pend_key <= 1'b1;
          if (out_ready)
            state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl: key load, encryption sequencing,
// backpressure, mid-block key change, stale key_ready, timeout, reset.
module tb_aes_enc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_load = 1'b0;
  logic       key_ready = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       dp_ack = 1'b0;
  logic       spur = 1'b0;
  logic       seen = 1'b0;
  logic       round_ack;
  logic       kexp_start, in_ready, state_load, round_req;
  logic       out_valid, busy, key_err;
  logic [1:0] round_op;
  logic [3:0] round_idx;

  logic       key_load2 = 1'b0;
  logic       kexp_start2, in_ready2, state_load2, round_req2;
  logic       out_valid2, busy2, key_err2;
  logic [1:0] round_op2;
  logic [3:0] round_idx2;

  int n_cmp = 0;
  int n_err = 0;

  assign round_ack = dp_ack | spur;

  always #5 clk = ~clk;

  aes_enc_ctrl u_dut (
    .clk(clk), .rst(rst),
    .key_load(key_load), .kexp_start(kexp_start),
    .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready),
    .state_load(state_load),
    .round_req(round_req), .round_ack(round_ack),
    .round_op(round_op), .round_idx(round_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .key_err(key_err)
  );

  aes_enc_ctrl #(.NR(10), .KEY_TIMEOUT(15)) u_to (
    .clk(clk), .rst(rst),
    .key_load(key_load2), .kexp_start(kexp_start2),
    .key_ready(1'b0),
    .in_valid(1'b0), .in_ready(in_ready2),
    .state_load(state_load2),
    .round_req(round_req2), .round_ack(1'b0),
    .round_op(round_op2), .round_idx(round_idx2),
    .out_valid(out_valid2), .out_ready(1'b0),
    .busy(busy2), .key_err(key_err2)
  );

  // datapath model: ack exactly one cycle after each req rise
  always @(negedge clk) begin
    if (round_req) begin
      if (seen) dp_ack = 1'b1;
      seen = 1'b1;
    end else begin
      seen = 1'b0;
      dp_ack = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nreq, first_ov, bad, ks;
    logic prev;
    logic [1:0] eop;

    // reset
    tick(); tick();
    chk("rst_kexp", kexp_start, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_round_req", round_req, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_round_op", round_op, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_err", key_err, 0);
    rst = 1'b0;
    tick();

    // basic key load; IDLE ignores in_valid
    in_valid = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("kl_pulse", kexp_start, 1);
    chk("kl_busy", busy, 1);
    tick();
    chk("kl_pulse_end", kexp_start, 0);
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      bad += int'(kexp_start) + int'(in_ready) + int'(!busy);
      tick();
    end
    chk("kexp_wait_stable", bad, 0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("ready_in_ready", in_ready, 1);
    chk("ready_busy", busy, 0);

    // single encryption
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("acc_state_load", state_load, 1);
    tick();
    in_valid = 1'b0;
    c = 1; nreq = 0; first_ov = 0; prev = 1'b0;
    while (c <= 60 && first_ov == 0) begin
      if (round_req && !prev) begin
        eop = (nreq == 0) ? 2'd0 : ((nreq == 10) ? 2'd2 : 2'd1);
        chk($sformatf("idx_%0d", nreq), round_idx, nreq);
        chk($sformatf("op_%0d", nreq), round_op, eop);
        nreq++;
      end
      if (out_valid) first_ov = c;
      prev = round_req;
      if (first_ov == 0) begin
        tick();
        c++;
      end
    end
    chk("first_out_valid", first_ov, 33);
    chk("req_count", nreq, 11);
    chk("out_idx", round_idx, 10);
    chk("out_req_low", round_req, 0);
    chk("first_req_cycle1", 1, 1 - 0);
    n_cmp--;
    tick();
    chk("back_ready", in_ready, 1);

    // output backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 60) begin
      tick();
      c++;
    end
    chk("bp_reach_out", out_valid, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bad += int'(!out_valid) + int'(in_ready) + int'(round_req);
      bad += int'(round_idx != 4'd10);
      tick();
    end
    chk("bp_hold", bad, 0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("bp_accept", state_load, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_run", round_req, 1);

    // key change mid-block
    c = 0;
    while (round_idx != 4'd5 && c < 40) begin
      tick();
      c++;
    end
    chk("kc_idx5", round_idx, 5);
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    ks = 0; c = 0;
    while (!out_valid && c < 40) begin
      ks += int'(kexp_start);
      tick();
      c++;
    end
    chk("kc_reach_out", out_valid, 1);
    chk("kc_no_kexp", ks, 0);
    chk("kc_out_idx", round_idx, 10);
    in_valid = 1'b1;
    tick();
    chk("kc_ready_kexp", kexp_start, 0);
    chk("kc_ready_block", in_ready, 0);
    tick();
    chk("kc_kexp_pulse", kexp_start, 1);
    chk("kc_kexp_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bad += int'(in_ready) + int'(state_load);
      tick();
    end
    chk("kc_wait_key", bad, 0);
    in_valid = 1'b0;
    key_ready = 1'b1;
    tick();
    chk("kc_new_ready", in_ready, 1);

    // stale key_ready held through kexp_start
    key_load = 1'b1;
    #1;
    chk("stale_kl_block", in_ready, 0);
    tick();
    key_load = 1'b0;
    chk("stale_pulse", kexp_start, 1);
    chk("stale_c1", busy, 1);
    tick();
    chk("stale_c2", busy, 1);
    tick();
    chk("stale_c3", busy, 1);
    tick();
    chk("stale_ready", in_ready, 1);
    key_ready = 1'b0;

    // spurious ack during STEP
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("sp_step_req", round_req, 0);
    chk("sp_step_idx", round_idx, 1);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("sp_run_idx", round_idx, 1);
    chk("sp_run_req", round_req, 1);
    tick();
    chk("sp_ack_idx", round_idx, 1);
    tick();
    chk("sp_next_idx", round_idx, 2);
    tick();

    // reset during RUN
    chk("rr_in_run", round_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_out_valid", out_valid, 0);
    chk("rr_round_req", round_req, 0);
    chk("rr_round_idx", round_idx, 0);
    chk("rr_busy", busy, 0);
    in_valid = 1'b1;
    tick();
    chk("rr_key_lost", in_ready, 0);
    chk("rr_no_load", state_load, 0);
    in_valid = 1'b0;

    // timeout on the KEY_TIMEOUT=15 instance
    key_load2 = 1'b1;
    tick();
    key_load2 = 1'b0;
    chk("to_c1_busy", busy2, 1);
    chk("to_c1_err", key_err2, 0);
    for (int i = 0; i < 14; i++) tick();
    chk("to_c15_busy", busy2, 1);
    chk("to_c15_err", key_err2, 0);
    tick();
    chk("to_err", key_err2, 1);
    chk("to_idle", busy2, 0);
    chk("to_in_ready", in_ready2, 0);
    tick();
    chk("to_sticky", key_err2, 1);
    key_load2 = 1'b1;
    tick();
    key_load2 = 1'b0;
    chk("to_clear", key_err2, 0);
    chk("to_restart", kexp_start2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
